// File: rtl/square_recompose_if.sv
// Request/result bundle between the square-root unit and the recomposer.
// The master issues start with root/remainder; the slave returns the result.
interface square_recompose_if;
  logic        start;
  logic [7:0]  in_root;
  logic [8:0]  in_rem;
  logic [15:0] out_sq;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, in_root, in_rem,
    input  out_sq, busy, done, err
  );

  modport slave (
    input  start, in_root, in_rem,
    output out_sq, busy, done, err
  );
endinterface

// File: rtl/square_recompose.sv
// Rebuilds root*root + rem from a square-root result using an 8-step
// shift-and-add multiply; all state advances on the falling clock edge.
module square_recompose (
  input  logic              clk,
  input  logic              reset,
  square_recompose_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [7:0]  root_q, root_d;
  logic [8:0]  rem_q, rem_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] out_sq_q, out_sq_d;
  logic        err_q, err_d;

  logic [16:0] sum;
  logic        busy;
  logic        done;

  // State register
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (cnt_q == 3'd7) state_d = ADD;
      ADD:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state_q == CALC) || (state_q == ADD);
    done = (state_q == DONE);
  end

  // Extra carry bit lets an out-of-range remainder be detected and saturated
  assign sum = {1'b0, acc_q} + {8'b0, rem_q};

  always_comb begin
    root_d   = root_q;
    rem_d    = rem_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_sq_d = out_sq_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          root_d   = bus.in_root;
          rem_d    = bus.in_rem;
          mcand_d  = {8'b0, bus.in_root};
          mplier_d = bus.in_root;
          acc_d    = 16'd0;
          cnt_d    = 3'd0;
        end
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mplier_d = {1'b0, mplier_q[7:1]};
        mcand_d  = {mcand_q[14:0], 1'b0};
        cnt_d    = cnt_q + 3'd1;
      end
      ADD: begin
        out_sq_d = sum[16] ? 16'hFFFF : sum[15:0];
        err_d    = (rem_q > {root_q, 1'b0});
      end
      default: begin
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      root_q   <= 8'd0;
      rem_q    <= 9'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 8'd0;
      acc_q    <= 16'd0;
      cnt_q    <= 3'd0;
      out_sq_q <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      root_q   <= root_d;
      rem_q    <= rem_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_sq_q <= out_sq_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.out_sq = out_sq_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_square_recompose.sv
// Self-checking bench for square_recompose: directed table, corner-case
// sequences and randomized operations against an arithmetic reference.
`timescale 1ns/1ps
module tb_square_recompose;

  logic clk = 1'b1;
  logic reset;

  square_recompose_if bus ();

  square_recompose dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // DUT updates on negedge; bench samples and drives on posedge.
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  root;
    logic [8:0]  rem;
    logic [15:0] exp_sq;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [6];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] last_sq;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_sq(input int r, input int m);
    int s;
    s = r * r + m;
    if (s > 65535) return 16'hFFFF;
    return s[15:0];
  endfunction

  function automatic bit model_err(input int r, input int m);
    return m > 2 * r;
  endfunction

  // Issue one request and observe max_k sample points after the accepting edge.
  task automatic run_op(input string tag, input logic [7:0] r, input logic [8:0] m,
                        input int pre_edges, input bit scramble, input bit hold_chk,
                        input logic [15:0] held_val, input int max_k,
                        output int done_k, output int busy_n, output int done_n,
                        output logic [15:0] sq, output logic er);
    bit held_ok;
    held_ok = 1'b1;
    done_k  = 0;
    busy_n  = 0;
    done_n  = 0;
    sq      = '0;
    er      = 1'b0;
    bus.start   = 1'b1;
    bus.in_root = r;
    bus.in_rem  = m;
    repeat (pre_edges) @(negedge clk);
    @(negedge clk);
    for (int k = 1; k <= max_k; k++) begin
      @(posedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_k == 0) begin
          done_k = k;
          sq     = bus.out_sq;
          er     = bus.err;
        end
      end else if (hold_chk && done_k == 0 && bus.out_sq !== held_val) begin
        held_ok = 1'b0;
      end
      if (scramble && k < 10) begin
        bus.start   = 1'b1;
        bus.in_root = 8'($urandom);
        bus.in_rem  = 9'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    if (hold_chk) check({tag, " out_sq held"}, int'(held_ok), 1);
  endtask

  task automatic do_op(input string tag, input logic [7:0] r, input logic [8:0] m,
                       input logic [15:0] exp_sq, input bit exp_err,
                       input int pre_edges, input bit scramble, input bit hold_chk,
                       input int max_k);
    int dk, bn, dn;
    logic [15:0] sq;
    logic er;
    run_op(tag, r, m, pre_edges, scramble, hold_chk, last_sq, max_k, dk, bn, dn, sq, er);
    check({tag, " latency"}, dk, 10);
    check({tag, " busy cycles"}, bn, 9);
    check({tag, " done count"}, dn, 1);
    check({tag, " out_sq"}, int'(sq), int'(exp_sq));
    check({tag, " err"}, int'(er), int'(exp_err));
    $display("op %s root=%0d rem=%0d out_sq=%0d err=%0d (exp %0d/%0d)",
             tag, r, m, sq, er, exp_sq, exp_err);
    last_sq = exp_sq;
  endtask

  initial begin
    int dn, bn;
    logic [7:0] r;
    logic [8:0] m;

    vecs[0] = '{root: 8'd12,  rem: 9'd5,   exp_sq: 16'd149,   exp_err: 1'b0};
    vecs[1] = '{root: 8'd0,   rem: 9'd0,   exp_sq: 16'd0,     exp_err: 1'b0};
    vecs[2] = '{root: 8'd255, rem: 9'd510, exp_sq: 16'd65535, exp_err: 1'b0};
    vecs[3] = '{root: 8'd200, rem: 9'd401, exp_sq: 16'd40401, exp_err: 1'b1};
    vecs[4] = '{root: 8'd255, rem: 9'd511, exp_sq: 16'hFFFF,  exp_err: 1'b1};
    vecs[5] = '{root: 8'd3,   rem: 9'd2,   exp_sq: 16'd11,    exp_err: 1'b0};

    bus.start   = 1'b0;
    bus.in_root = '0;
    bus.in_rem  = '0;
    reset       = 1'b1;
    last_sq     = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    check("reset out_sq", int'(bus.out_sq), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset err", int'(bus.err), 0);
    $display("reset out_sq=%0d busy=%0d done=%0d err=%0d",
             bus.out_sq, bus.busy, bus.done, bus.err);

    // Start on the very first edge after reset releases.
    reset = 1'b0;
    do_op("basic", vecs[0].root, vecs[0].rem, vecs[0].exp_sq, vecs[0].exp_err, 0, 1'b0, 1'b0, 13);
    for (int i = 1; i < 5; i++)
      do_op($sformatf("vec%0d", i), vecs[i].root, vecs[i].rem, vecs[i].exp_sq, vecs[i].exp_err,
            0, 1'b0, 1'b0, 13);

    // Start held and inputs scrambled while busy.
    do_op("ignored_start", 8'd77, 9'd40, model_sq(77, 40), model_err(77, 40), 0, 1'b1, 1'b0, 14);

    // Back-to-back: second start raised during DONE, accepted on the next IDLE edge.
    do_op("b2b_first", 8'd9, 9'd4, model_sq(9, 4), model_err(9, 4), 0, 1'b0, 1'b0, 10);
    do_op("b2b_second", 8'd50, 9'd0, model_sq(50, 0), model_err(50, 0), 1, 1'b0, 1'b1, 13);

    // Reset on the 4th CALC edge aborts the operation.
    bus.start   = 1'b1;
    bus.in_root = 8'd100;
    bus.in_rem  = 9'd7;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    reset = 1'b0;
    dn = 0;
    bn = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      if (bus.done) dn++;
      if (bus.busy) bn++;
    end
    check("abort done count", dn, 0);
    check("abort busy count", bn, 0);
    check("abort out_sq", int'(bus.out_sq), 0);
    check("abort err", int'(bus.err), 0);
    $display("abort done=%0d busy=%0d out_sq=%0d", dn, bn, bus.out_sq);
    last_sq = '0;
    do_op("after_abort", vecs[5].root, vecs[5].rem, vecs[5].exp_sq, vecs[5].exp_err, 0, 1'b0, 1'b0, 13);

    // Randomized operations with idle gaps.
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(posedge clk);
      check($sformatf("rand%0d idle hold", i), int'(bus.out_sq), int'(last_sq));
      r = 8'($urandom);
      m = (i % 4 == 0) ? 9'($urandom) : 9'($urandom_range(0, 2 * int'(r)));
      do_op($sformatf("rand%0d", i), r, m, model_sq(int'(r), int'(m)),
            model_err(int'(r), int'(m)), 0, 1'b0, 1'b0, 11);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
